axi_lite_dbus_arbiter: RTL and testbench

//   Two-master -> one-slave AXI-Lite arbiter that shares the peripheral (AXI-APB bridge) port between
//   the CPU data bus (s0) and a second bus master such as DMA or debug (s1). Read and write paths are

---
 rtl/axi_lite_dbus_arbiter.sv | 241 ++++++++++++++++++++++++
 tb/tb_axi_lite_dbus_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_dbus_arbiter.sv
// Two-master to one-slave AXI-Lite arbiter for the peripheral bridge port.
// Read and write paths are arbitrated independently, one outstanding
// transaction per path. rd_state_dbg / wr_state_dbg expose the FSM states.
//
// Handshake rules: a beat transfers on any edge where valid and ready are both
// high. A source holds valid (and its payload) until that edge. Readiness is
// never promised ahead of time. Only the granted master's channels are
// connected to the slave. The other master always sees ready/rvalid/bvalid low.
module axi_lite_dbus_arbiter #(
  parameter string arb_mode         = "round_robin",
  parameter int    simulation_delay = 0
) (
  input  logic        clk,
  input  logic        rst,
  // master 0 (CPU data bus)
  input  logic [31:0] s0_axi_araddr,
  input  logic        s0_axi_arvalid,
  output logic        s0_axi_arready,
  output logic [31:0] s0_axi_rdata,
  output logic [1:0]  s0_axi_rresp,
  output logic        s0_axi_rvalid,
  input  logic        s0_axi_rready,
  input  logic [31:0] s0_axi_awaddr,
  input  logic        s0_axi_awvalid,
  output logic        s0_axi_awready,
  input  logic [31:0] s0_axi_wdata,
  input  logic [3:0]  s0_axi_wstrb,
  input  logic        s0_axi_wvalid,
  output logic        s0_axi_wready,
  output logic [1:0]  s0_axi_bresp,
  output logic        s0_axi_bvalid,
  input  logic        s0_axi_bready,
  // master 1 (DMA / debug)
  input  logic [31:0] s1_axi_araddr,
  input  logic        s1_axi_arvalid,
  output logic        s1_axi_arready,
  output logic [31:0] s1_axi_rdata,
  output logic [1:0]  s1_axi_rresp,
  output logic        s1_axi_rvalid,
  input  logic        s1_axi_rready,
  input  logic [31:0] s1_axi_awaddr,
  input  logic        s1_axi_awvalid,
  output logic        s1_axi_awready,
  input  logic [31:0] s1_axi_wdata,
  input  logic [3:0]  s1_axi_wstrb,
  input  logic        s1_axi_wvalid,
  output logic        s1_axi_wready,
  output logic [1:0]  s1_axi_bresp,
  output logic        s1_axi_bvalid,
  input  logic        s1_axi_bready,
  // slave side (AXI-APB bridge)
  output logic [31:0] m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  output logic [31:0] m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  // ownership and debug
  output logic [1:0]  rd_grant,
  output logic [1:0]  wr_grant,
  output logic [1:0]  rd_state_dbg,
  output logic [1:0]  wr_state_dbg
);

  localparam bit fixed_mode = (arb_mode == "fixed");

  // The output delay only matters to behavioural models. This synthesizable
  // core applies no delay.
  if (simulation_delay != 0) begin : g_sim_delay_ignored
  end

  typedef enum logic [1:0] {RD_IDLE = 2'd0, RD_ADDR = 2'd1, RD_RESP = 2'd2} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE = 2'd0, WR_ADDR = 2'd1, WR_RESP = 2'd2} wr_state_t;

  rd_state_t  rd_state, rd_state_next;
  wr_state_t  wr_state, wr_state_next;
  logic [1:0] rd_grant_next, wr_grant_next;
  logic       last_rd_owner, last_rd_owner_next;   // 1 = master 1 owned last
  logic       last_wr_owner, last_wr_owner_next;
  logic       aw_done, aw_done_next, w_done, w_done_next;
  logic       aw_hs, w_hs;

  // One-hot winner among the requesters. When both request, the master that
  // did not own the path last wins, or master 0 in fixed mode.
  function automatic logic [1:0] pick(input logic req0, input logic req1, input logic last);
    if (req0 && req1) return (fixed_mode || last) ? 2'b01 : 2'b10;
    else if (req0)    return 2'b01;
    else if (req1)    return 2'b10;
    else              return 2'b00;
  endfunction

  assign rd_state_dbg = rd_state;
  assign wr_state_dbg = wr_state;

  // State, grant, owner-history and write-flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state      <= RD_IDLE;
      wr_state      <= WR_IDLE;
      rd_grant      <= 2'b00;
      wr_grant      <= 2'b00;
      last_rd_owner <= 1'b1;
      last_wr_owner <= 1'b1;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
    end else begin
      rd_state      <= rd_state_next;
      wr_state      <= wr_state_next;
      rd_grant      <= rd_grant_next;
      wr_grant      <= wr_grant_next;
      last_rd_owner <= last_rd_owner_next;
      last_wr_owner <= last_wr_owner_next;
      aw_done       <= aw_done_next;
      w_done        <= w_done_next;
    end
  end

  // Read path next state. The release cycle always returns to idle, so a new
  // grant can never be issued in the same cycle as a release.
  always_comb begin
    rd_state_next      = rd_state;
    rd_grant_next      = rd_grant;
    last_rd_owner_next = last_rd_owner;
    case (rd_state)
      RD_IDLE: begin
        if (s0_axi_arvalid || s1_axi_arvalid) begin
          rd_state_next = RD_ADDR;
          rd_grant_next = pick(s0_axi_arvalid, s1_axi_arvalid, last_rd_owner);
        end
      end
      RD_ADDR: begin
        if (m_axi_arvalid && m_axi_arready) rd_state_next = RD_RESP;
      end
      RD_RESP: begin
        if (m_axi_rvalid && m_axi_rready) begin
          rd_state_next      = RD_IDLE;
          last_rd_owner_next = rd_grant[1];
          rd_grant_next      = 2'b00;
        end
      end
      default: begin
        rd_state_next = RD_IDLE;
        rd_grant_next = 2'b00;
      end
    endcase
  end

  // Write path next state. AW and W complete independently, in either order,
  // and the response phase starts once both have completed.
  always_comb begin
    wr_state_next      = wr_state;
    wr_grant_next      = wr_grant;
    last_wr_owner_next = last_wr_owner;
    aw_done_next       = aw_done;
    w_done_next        = w_done;
    case (wr_state)
      WR_IDLE: begin
        if (s0_axi_awvalid || s1_axi_awvalid) begin
          wr_state_next = WR_ADDR;
          wr_grant_next = pick(s0_axi_awvalid, s1_axi_awvalid, last_wr_owner);
        end
      end
      WR_ADDR: begin
        if ((aw_done || aw_hs) && (w_done || w_hs)) begin
          wr_state_next = WR_RESP;
          aw_done_next  = 1'b0;
          w_done_next   = 1'b0;
        end else begin
          aw_done_next  = aw_done || aw_hs;
          w_done_next   = w_done || w_hs;
        end
      end
      WR_RESP: begin
        if (m_axi_bvalid && m_axi_bready) begin
          wr_state_next      = WR_IDLE;
          last_wr_owner_next = wr_grant[1];
          wr_grant_next      = 2'b00;
        end
      end
      default: begin
        wr_state_next = WR_IDLE;
        wr_grant_next = 2'b00;
        aw_done_next  = 1'b0;
        w_done_next   = 1'b0;
      end
    endcase
  end

  // Read channel routing. Payload muxes fall back to master 0 when idle.
  always_comb begin
    m_axi_araddr   = rd_grant[1] ? s1_axi_araddr : s0_axi_araddr;
    m_axi_arvalid  = (rd_state == RD_ADDR) &&
                     ((rd_grant[0] && s0_axi_arvalid) || (rd_grant[1] && s1_axi_arvalid));
    s0_axi_arready = (rd_state == RD_ADDR) && rd_grant[0] && m_axi_arready;
    s1_axi_arready = (rd_state == RD_ADDR) && rd_grant[1] && m_axi_arready;
    m_axi_rready   = (rd_state == RD_RESP) &&
                     ((rd_grant[0] && s0_axi_rready) || (rd_grant[1] && s1_axi_rready));
    s0_axi_rvalid  = (rd_state == RD_RESP) && rd_grant[0] && m_axi_rvalid;
    s1_axi_rvalid  = (rd_state == RD_RESP) && rd_grant[1] && m_axi_rvalid;
    s0_axi_rdata   = m_axi_rdata;
    s1_axi_rdata   = m_axi_rdata;
    s0_axi_rresp   = m_axi_rresp;
    s1_axi_rresp   = m_axi_rresp;
  end

  // Write channel routing. Completed AW or W beats are masked until the
  // response phase.
  always_comb begin
    m_axi_awaddr   = wr_grant[1] ? s1_axi_awaddr : s0_axi_awaddr;
    m_axi_wdata    = wr_grant[1] ? s1_axi_wdata  : s0_axi_wdata;
    m_axi_wstrb    = wr_grant[1] ? s1_axi_wstrb  : s0_axi_wstrb;
    m_axi_awvalid  = (wr_state == WR_ADDR) && !aw_done &&
                     ((wr_grant[0] && s0_axi_awvalid) || (wr_grant[1] && s1_axi_awvalid));
    m_axi_wvalid   = (wr_state == WR_ADDR) && !w_done &&
                     ((wr_grant[0] && s0_axi_wvalid) || (wr_grant[1] && s1_axi_wvalid));
    aw_hs          = m_axi_awvalid && m_axi_awready;
    w_hs           = m_axi_wvalid && m_axi_wready;
    s0_axi_awready = (wr_state == WR_ADDR) && !aw_done && wr_grant[0] && m_axi_awready;
    s1_axi_awready = (wr_state == WR_ADDR) && !aw_done && wr_grant[1] && m_axi_awready;
    s0_axi_wready  = (wr_state == WR_ADDR) && !w_done && wr_grant[0] && m_axi_wready;
    s1_axi_wready  = (wr_state == WR_ADDR) && !w_done && wr_grant[1] && m_axi_wready;
    m_axi_bready   = (wr_state == WR_RESP) &&
                     ((wr_grant[0] && s0_axi_bready) || (wr_grant[1] && s1_axi_bready));
    s0_axi_bvalid  = (wr_state == WR_RESP) && wr_grant[0] && m_axi_bvalid;
    s1_axi_bvalid  = (wr_state == WR_RESP) && wr_grant[1] && m_axi_bvalid;
    s0_axi_bresp   = m_axi_bresp;
    s1_axi_bresp   = m_axi_bresp;
  end

endmodule

// File: tb/tb_axi_lite_dbus_arbiter.sv
// Directed bench for axi_lite_dbus_arbiter. A round-robin and a fixed-priority
// instance share every input. The bench drives both masters and the slave.
module tb_axi_lite_dbus_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- stimulus ----------------
  logic [31:0] s0_araddr, s1_araddr, s0_awaddr, s1_awaddr, s0_wdata, s1_wdata;
  logic [3:0]  s0_wstrb, s1_wstrb;
  logic        s0_arvalid, s1_arvalid, s0_rready, s1_rready;
  logic        s0_awvalid, s1_awvalid, s0_wvalid, s1_wvalid, s0_bready, s1_bready;
  logic        m_arready, m_rvalid, m_awready, m_wready, m_bvalid;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp, m_bresp;

  // ---------------- round-robin instance outputs ----------------
  logic        s0_arready, s1_arready, s0_rvalid, s1_rvalid, s0_awready, s1_awready;
  logic        s0_wready, s1_wready, s0_bvalid, s1_bvalid;
  logic [31:0] s0_rdata, s1_rdata;
  logic [1:0]  s0_rresp, s1_rresp, s0_bresp, s1_bresp;
  logic [31:0] m_araddr, m_awaddr, m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready;
  logic [1:0]  rd_grant, wr_grant, rd_state_dbg, wr_state_dbg;

  // ---------------- fixed instance outputs ----------------
  logic        f_s0_arready, f_s1_arready, f_s0_rvalid, f_s1_rvalid, f_s0_awready, f_s1_awready;
  logic        f_s0_wready, f_s1_wready, f_s0_bvalid, f_s1_bvalid;
  logic [31:0] f_s0_rdata, f_s1_rdata;
  logic [1:0]  f_s0_rresp, f_s1_rresp, f_s0_bresp, f_s1_bresp;
  logic [31:0] f_m_araddr, f_m_awaddr, f_m_wdata;
  logic [3:0]  f_m_wstrb;
  logic        f_m_arvalid, f_m_rready, f_m_awvalid, f_m_wvalid, f_m_bready;
  logic [1:0]  f_rd_grant, f_wr_grant, f_rd_state_dbg, f_wr_state_dbg;

  axi_lite_dbus_arbiter #(.arb_mode("round_robin")) dut (
    .clk(clk), .rst(rst),
    .s0_axi_araddr(s0_araddr), .s0_axi_arvalid(s0_arvalid), .s0_axi_arready(s0_arready),
    .s0_axi_rdata(s0_rdata), .s0_axi_rresp(s0_rresp), .s0_axi_rvalid(s0_rvalid), .s0_axi_rready(s0_rready),
    .s0_axi_awaddr(s0_awaddr), .s0_axi_awvalid(s0_awvalid), .s0_axi_awready(s0_awready),
    .s0_axi_wdata(s0_wdata), .s0_axi_wstrb(s0_wstrb), .s0_axi_wvalid(s0_wvalid), .s0_axi_wready(s0_wready),
    .s0_axi_bresp(s0_bresp), .s0_axi_bvalid(s0_bvalid), .s0_axi_bready(s0_bready),
    .s1_axi_araddr(s1_araddr), .s1_axi_arvalid(s1_arvalid), .s1_axi_arready(s1_arready),
    .s1_axi_rdata(s1_rdata), .s1_axi_rresp(s1_rresp), .s1_axi_rvalid(s1_rvalid), .s1_axi_rready(s1_rready),
    .s1_axi_awaddr(s1_awaddr), .s1_axi_awvalid(s1_awvalid), .s1_axi_awready(s1_awready),
    .s1_axi_wdata(s1_wdata), .s1_axi_wstrb(s1_wstrb), .s1_axi_wvalid(s1_wvalid), .s1_axi_wready(s1_wready),
    .s1_axi_bresp(s1_bresp), .s1_axi_bvalid(s1_bvalid), .s1_axi_bready(s1_bready),
    .m_axi_araddr(m_araddr), .m_axi_arvalid(m_arvalid), .m_axi_arready(m_arready),
    .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp), .m_axi_rvalid(m_rvalid), .m_axi_rready(m_rready),
    .m_axi_awaddr(m_awaddr), .m_axi_awvalid(m_awvalid), .m_axi_awready(m_awready),
    .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb), .m_axi_wvalid(m_wvalid), .m_axi_wready(m_wready),
    .m_axi_bresp(m_bresp), .m_axi_bvalid(m_bvalid), .m_axi_bready(m_bready),
    .rd_grant(rd_grant), .wr_grant(wr_grant), .rd_state_dbg(rd_state_dbg), .wr_state_dbg(wr_state_dbg)
  );

  axi_lite_dbus_arbiter #(.arb_mode("fixed")) dut_fixed (
    .clk(clk), .rst(rst),
    .s0_axi_araddr(s0_araddr), .s0_axi_arvalid(s0_arvalid), .s0_axi_arready(f_s0_arready),
    .s0_axi_rdata(f_s0_rdata), .s0_axi_rresp(f_s0_rresp), .s0_axi_rvalid(f_s0_rvalid), .s0_axi_rready(s0_rready),
    .s0_axi_awaddr(s0_awaddr), .s0_axi_awvalid(s0_awvalid), .s0_axi_awready(f_s0_awready),
    .s0_axi_wdata(s0_wdata), .s0_axi_wstrb(s0_wstrb), .s0_axi_wvalid(s0_wvalid), .s0_axi_wready(f_s0_wready),
    .s0_axi_bresp(f_s0_bresp), .s0_axi_bvalid(f_s0_bvalid), .s0_axi_bready(s0_bready),
    .s1_axi_araddr(s1_araddr), .s1_axi_arvalid(s1_arvalid), .s1_axi_arready(f_s1_arready),
    .s1_axi_rdata(f_s1_rdata), .s1_axi_rresp(f_s1_rresp), .s1_axi_rvalid(f_s1_rvalid), .s1_axi_rready(s1_rready),
    .s1_axi_awaddr(s1_awaddr), .s1_axi_awvalid(s1_awvalid), .s1_axi_awready(f_s1_awready),
    .s1_axi_wdata(s1_wdata), .s1_axi_wstrb(s1_wstrb), .s1_axi_wvalid(s1_wvalid), .s1_axi_wready(f_s1_wready),
    .s1_axi_bresp(f_s1_bresp), .s1_axi_bvalid(f_s1_bvalid), .s1_axi_bready(s1_bready),
    .m_axi_araddr(f_m_araddr), .m_axi_arvalid(f_m_arvalid), .m_axi_arready(m_arready),
    .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp), .m_axi_rvalid(m_rvalid), .m_axi_rready(f_m_rready),
    .m_axi_awaddr(f_m_awaddr), .m_axi_awvalid(f_m_awvalid), .m_axi_awready(m_awready),
    .m_axi_wdata(f_m_wdata), .m_axi_wstrb(f_m_wstrb), .m_axi_wvalid(f_m_wvalid), .m_axi_wready(m_wready),
    .m_axi_bresp(m_bresp), .m_axi_bvalid(m_bvalid), .m_axi_bready(f_m_bready),
    .rd_grant(f_rd_grant), .wr_grant(f_wr_grant), .rd_state_dbg(f_rd_state_dbg), .wr_state_dbg(f_wr_state_dbg)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int aw_beats = 0;
  int w_beats  = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Scoreboard: every read beat accepted by master 0 must match the queue head.
  always @(negedge clk) begin
    if (!rst && s0_rvalid && s0_rready) begin
      if (exp_q.size() == 0) check("sb_queue_size", exp_q.size(), 32'd1);
      else                   check("sb_s0_rdata", s0_rdata, exp_q.pop_front());
    end
  end

  // Beat counters on the slave-side write channels.
  always @(posedge clk) begin
    if (!rst && m_awvalid && m_awready) aw_beats++;
    if (!rst && m_wvalid && m_wready)   w_beats++;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    s0_araddr = 32'h0; s0_arvalid = 0; s0_rready = 0;
    s1_araddr = 32'h0; s1_arvalid = 0; s1_rready = 0;
    s0_awaddr = 32'h0; s0_awvalid = 0; s0_wdata = 32'h0; s0_wstrb = 4'h0; s0_wvalid = 0; s0_bready = 0;
    s1_awaddr = 32'h0; s1_awvalid = 0; s1_wdata = 32'h0; s1_wstrb = 4'h0; s1_wvalid = 0; s1_bready = 0;
    m_arready = 0; m_rvalid = 0; m_rdata = 32'h0; m_rresp = 2'b00;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 2'b00;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) step();
    rst = 1'b0;
  endtask

  // One contended read round, entered from idle with requests already up.
  // g is the round-robin winner, fexp the fixed-mode grant.
  task automatic rd_cycle(input int g, input logic [31:0] data, input logic [1:0] fexp);
    step();
    check("rr_grant", rd_grant, (g != 0) ? 2'b10 : 2'b01);
    check("fixed_grant", f_rd_grant, fexp);
    check("rr_araddr", m_araddr, (g != 0) ? 32'h0000_0200 : 32'h0000_0100);
    m_arready = 1;
    #1;
    check("rr_loser_arready", (g != 0) ? s0_arready : s1_arready, 32'd0);
    step();
    m_arready = 0;
    m_rvalid = 1;
    m_rdata = data;
    m_rresp = 2'b00;
    if (g == 0) exp_q.push_back(data);
    #1;
    check("rr_loser_rvalid", (g != 0) ? s0_rvalid : s1_rvalid, 32'd0);
    if (g != 0) check("rr_s1_rdata", s1_rvalid ? s1_rdata : 32'h0, data);
    step();
    m_rvalid = 0;
    #1;
    check("rr_release", rd_grant, 2'b00);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    clear_inputs();
    repeat (2) step();
    check("rst_rd_grant", rd_grant, 2'b00);
    check("rst_wr_grant", wr_grant, 2'b00);
    check("rst_m_valids", {m_arvalid, m_awvalid, m_wvalid}, 3'b000);
    rst = 1'b0;
    step();

    // 1: single read by master 0
    s0_araddr = 32'h4000_0004; s0_arvalid = 1; s0_rready = 1;
    #1;
    check("t1_no_grant_yet", rd_grant, 2'b00);
    check("t1_no_arvalid_yet", m_arvalid, 1'b0);
    step();
    check("t1_grant", rd_grant, 2'b01);
    check("t1_m_arvalid", m_arvalid, 1'b1);
    check("t1_m_araddr", m_araddr, 32'h4000_0004);
    m_arready = 1;
    #1;
    check("t1_s0_arready", s0_arready, 1'b1);
    check("t1_s1_arready", s1_arready, 1'b0);
    step();
    s0_arvalid = 0; m_arready = 0;
    m_rvalid = 1; m_rdata = 32'hDEAD_BEEF; m_rresp = 2'b00;
    exp_q.push_back(32'hDEAD_BEEF);
    #1;
    check("t1_m_arvalid_off", m_arvalid, 1'b0);
    check("t1_s1_rvalid", s1_rvalid, 1'b0);
    check("t1_rresp", s0_rresp, 2'b00);
    step();
    m_rvalid = 0;
    check("t1_release", rd_grant, 2'b00);

    // 2: persistent contention, 4 rounds, then master 0 drops out
    apply_reset();
    s0_araddr = 32'h0000_0100; s1_araddr = 32'h0000_0200;
    s0_rready = 1; s1_rready = 1;
    s0_arvalid = 1; s1_arvalid = 1;
    rd_cycle(0, 32'h1111_0000, 2'b01);
    rd_cycle(1, 32'h2222_0001, 2'b01);
    rd_cycle(0, 32'h3333_0002, 2'b01);
    rd_cycle(1, 32'h4444_0003, 2'b01);
    s0_arvalid = 0;
    rd_cycle(1, 32'h5555_0004, 2'b10);
    s1_arvalid = 0;

    // 3: master 1 write with W presented three cycles ahead of AW
    s1_wdata = 32'h0000_00A5; s1_wstrb = 4'b0001; s1_wvalid = 1; s1_bready = 1;
    m_awready = 1; m_wready = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t3_w_alone_no_grant", wr_grant, 2'b00);
      check("t3_w_alone_wready", s1_wready, 1'b0);
    end
    s1_awaddr = 32'h4000_1000; s1_awvalid = 1;
    aw_beats = 0; w_beats = 0;
    step();
    check("t3_grant", wr_grant, 2'b10);
    check("t3_m_awaddr", m_awaddr, 32'h4000_1000);
    check("t3_m_wdata", m_wdata, 32'h0000_00A5);
    check("t3_m_wstrb", m_wstrb, 4'b0001);
    check("t3_s0_awready", s0_awready, 1'b0);
    step();
    s1_awvalid = 0; s1_wvalid = 0;
    m_bvalid = 1; m_bresp = 2'b00;
    #1;
    check("t3_s1_bvalid", s1_bvalid, 1'b1);
    check("t3_s0_bvalid", s0_bvalid, 1'b0);
    check("t3_bresp", s1_bresp, 2'b00);
    step();
    m_bvalid = 0;
    check("t3_release", wr_grant, 2'b00);
    check("t3_aw_beats", aw_beats, 32'd1);
    check("t3_w_beats", w_beats, 32'd1);

    // 4: master 0 read and master 1 write at the same time
    s0_araddr = 32'h4000_0008; s0_arvalid = 1; s0_rready = 1;
    s1_awaddr = 32'h0000_2000; s1_awvalid = 1;
    s1_wdata = 32'h1234_5678; s1_wstrb = 4'hF; s1_wvalid = 1; s1_bready = 1;
    m_arready = 1; m_awready = 1; m_wready = 1;
    step();
    check("t4_rd_grant", rd_grant, 2'b01);
    check("t4_wr_grant", wr_grant, 2'b10);
    check("t4_m_araddr", m_araddr, 32'h4000_0008);
    check("t4_m_wdata", m_wdata, 32'h1234_5678);
    step();
    s0_arvalid = 0; s1_awvalid = 0; s1_wvalid = 0;
    m_arready = 0; m_awready = 0; m_wready = 0;
    m_rvalid = 1; m_rdata = 32'hCAFE_F00D; m_rresp = 2'b11;
    m_bvalid = 1; m_bresp = 2'b00;
    exp_q.push_back(32'hCAFE_F00D);
    #1;
    check("t4_rresp_decerr", s0_rresp, 2'b11);
    check("t4_s1_bvalid", s1_bvalid, 1'b1);
    check("t4_s0_bvalid", s0_bvalid, 1'b0);
    step();
    m_rvalid = 0; m_bvalid = 0; m_rresp = 2'b00;
    check("t4_release", {rd_grant, wr_grant}, 4'b0000);

    // 5: master 0 write, bready held low 5 cycles, SLVERR; master 1 waiting
    s0_awaddr = 32'h0000_3000; s0_awvalid = 1;
    s0_wdata = 32'h0000_0055; s0_wstrb = 4'hF; s0_wvalid = 1; s0_bready = 0;
    m_awready = 1; m_wready = 1;
    step();
    check("t5_grant_s0", wr_grant, 2'b01);
    s1_awaddr = 32'h0000_4000; s1_awvalid = 1;
    s1_wdata = 32'h0000_0066; s1_wstrb = 4'b0011; s1_wvalid = 1; s1_bready = 1;
    step();
    s0_awvalid = 0; s0_wvalid = 0;
    m_bvalid = 1; m_bresp = 2'b10;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t5_hold_grant", wr_grant, 2'b01);
      check("t5_s0_bvalid", s0_bvalid, 1'b1);
      check("t5_slverr", s0_bresp, 2'b10);
      check("t5_m_bready_low", m_bready, 1'b0);
      check("t5_s1_awready", s1_awready, 1'b0);
      step();
    end
    s0_bready = 1;
    #1;
    check("t5_m_bready", m_bready, 1'b1);
    step();
    m_bvalid = 0; m_bresp = 2'b00; s0_bready = 0;
    check("t5_idle_gap", wr_grant, 2'b00);
    step();
    check("t5_grant_s1", wr_grant, 2'b10);
    check("t5_m_awaddr", m_awaddr, 32'h0000_4000);
    check("t5_m_wstrb", m_wstrb, 4'b0011);
    step();
    s1_awvalid = 0; s1_wvalid = 0;
    m_bvalid = 1;
    #1;
    check("t5_s1_bvalid", s1_bvalid, 1'b1);
    step();
    m_bvalid = 0;
    check("t5_release", wr_grant, 2'b00);

    // 6: reset while read is in RD_RESP and write has only its AW done
    s0_araddr = 32'h0000_0500; s0_arvalid = 1; s0_rready = 0;
    s1_awaddr = 32'h0000_0600; s1_awvalid = 1; s1_wvalid = 0;
    m_arready = 1; m_awready = 1; m_wready = 1;
    step();
    step();
    s0_arvalid = 0; s1_awvalid = 0; m_arready = 0; m_awready = 0;
    m_rvalid = 1; m_rdata = 32'h0BAD_0BAD;
    #1;
    check("t6_rd_state_resp", rd_state_dbg, 2'd2);
    check("t6_wr_state_addr", wr_state_dbg, 2'd1);
    check("t6_aw_masked", m_awvalid, 1'b0);
    check("t6_s0_rvalid", s0_rvalid, 1'b1);
    rst = 1'b1;
    #1;
    check("t6_grants", {rd_grant, wr_grant}, 4'b0000);
    check("t6_valids", {m_arvalid, m_awvalid, m_wvalid, s0_rvalid, s1_bvalid}, 5'b00000);
    check("t6_readys", {m_rready, m_bready, s1_wready, s1_awready, s0_arready}, 5'b00000);
    clear_inputs();
    step();
    rst = 1'b0;
    s0_araddr = 32'h0000_0100; s1_araddr = 32'h0000_0200;
    s0_arvalid = 1; s1_arvalid = 1;
    step();
    check("t6_contention_s0", rd_grant, 2'b01);
    check("t6_fixed_s0", f_rd_grant, 2'b01);
    clear_inputs();
    step();

    check("sb_drain", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
